// File: rtl/axi_addr_ch_tx.sv
// ============================================================================
// Module   : axi_addr_ch_tx
// Brief    : In-order AXI AR/AW address-channel transmitter with FIFO,
//            output register, bypass path and translation-fault drop/report.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi_addr_ch_tx #(
    parameter int unsigned BUF_SZ     = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned USER_WIDTH = 2
) (
    input  logic                          tx_clk,
    input  logic                          reset,

    input  logic [ID_WIDTH-1:0]           in_id,
    input  logic [ADDR_WIDTH-1:0]         in_addr,
    input  logic [7:0]                    in_len,
    input  logic [2:0]                    in_size,
    input  logic [1:0]                    in_burst,
    input  logic [2:0]                    in_prot,
    input  logic [3:0]                    in_cache,
    input  logic [USER_WIDTH-1:0]         in_user,
    input  logic                          in_lock,
    input  logic                          in_fault,
    input  logic                          in_valid,
    output logic                          in_ready,

    output logic [ID_WIDTH-1:0]           out_id,
    output logic [ADDR_WIDTH-1:0]         out_addr,
    output logic [7:0]                    out_len,
    output logic [2:0]                    out_size,
    output logic [1:0]                    out_burst,
    output logic [2:0]                    out_prot,
    output logic [3:0]                    out_cache,
    output logic [USER_WIDTH-1:0]         out_user,
    output logic                          out_lock,
    output logic                          out_valid,
    input  logic                          out_ready,

    output logic [$clog2(BUF_SZ+1):0]     o_count,
    output logic                          o_fault,
    output logic [ID_WIDTH-1:0]           o_fault_id,
    output logic [ADDR_WIDTH-1:0]         o_fault_addr,
    output logic [15:0]                   o_fault_cnt
);

    localparam int unsigned c_PW    = 21 + ID_WIDTH + ADDR_WIDTH + USER_WIDTH;
    localparam int unsigned c_PTR_W = (BUF_SZ > 1) ? $clog2(BUF_SZ) : 1;
    localparam int unsigned c_CNT_W = $clog2(BUF_SZ + 1);
    localparam int unsigned c_OC_W  = c_CNT_W + 1;
    localparam int unsigned c_ID_LO = 21;
    localparam int unsigned c_AD_LO = 21 + ID_WIDTH;

    logic [c_PW-1:0]     r_mem [BUF_SZ];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_fifo_count;
    logic [c_PW-1:0]     r_out_pay;
    logic                r_out_valid;
    logic                r_fault;
    logic [ID_WIDTH-1:0] r_fault_id;
    logic [ADDR_WIDTH-1:0] r_fault_addr;
    logic [15:0]         r_fault_cnt;

    logic [c_PW-1:0]     w_in_pay;
    logic                w_accept;
    logic                w_store;
    logic                w_free;
    logic                w_fifo_empty;
    logic                w_pop;
    logic                w_bypass;
    logic                w_push;

    // Fixed packing: len, size, burst, prot, cache, lock, id, addr, user (LSB->MSB)
    assign w_in_pay = {in_user, in_addr, in_id, in_lock, in_cache,
                       in_prot, in_burst, in_size, in_len};

    assign in_ready     = (r_fifo_count != c_CNT_W'(BUF_SZ));
    assign w_accept     = in_valid & in_ready;
    assign w_store      = w_accept & ~in_fault;
    assign w_free       = ~r_out_valid | out_ready;
    assign w_fifo_empty = (r_fifo_count == '0);
    // Popping the head wins over bypass so ordering is never violated.
    assign w_pop        = w_free & ~w_fifo_empty;
    assign w_bypass     = w_store & w_fifo_empty & w_free;
    assign w_push       = w_store & ~w_bypass;

    always_ff @(posedge tx_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_pay;
        end
    end

    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + 1'b1;
                2'b01:   r_fifo_count <= r_fifo_count - 1'b1;
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            r_out_pay   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_pop) begin
            r_out_pay   <= r_mem[r_rd_ptr];
            r_out_valid <= 1'b1;
        end else if (w_bypass) begin
            r_out_pay   <= w_in_pay;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            r_fault      <= 1'b0;
            r_fault_id   <= '0;
            r_fault_addr <= '0;
            r_fault_cnt  <= '0;
        end else if (w_accept & in_fault) begin
            r_fault      <= 1'b1;
            r_fault_id   <= in_id;
            r_fault_addr <= in_addr;
            if (r_fault_cnt != 16'hFFFF) begin
                r_fault_cnt <= r_fault_cnt + 16'd1;
            end
        end else begin
            r_fault <= 1'b0;
        end
    end

    assign out_len      = r_out_pay[7:0];
    assign out_size     = r_out_pay[10:8];
    assign out_burst    = r_out_pay[12:11];
    assign out_prot     = r_out_pay[15:13];
    assign out_cache    = r_out_pay[19:16];
    assign out_lock     = r_out_pay[20];
    assign out_id       = r_out_pay[c_ID_LO +: ID_WIDTH];
    assign out_addr     = r_out_pay[c_AD_LO +: ADDR_WIDTH];
    assign out_user     = r_out_pay[c_PW-1 -: USER_WIDTH];
    assign out_valid    = r_out_valid;

    assign o_count      = c_OC_W'(r_fifo_count) + c_OC_W'(r_out_valid);
    assign o_fault      = r_fault;
    assign o_fault_id   = r_fault_id;
    assign o_fault_addr = r_fault_addr;
    assign o_fault_cnt  = r_fault_cnt;

endmodule

`default_nettype wire

// File: doc/axi_addr_ch_tx.md
# axi_addr_ch_tx

Address-channel transmitter for the AXI MMU path: accepts translated address requests from the translator, buffers them in order, and drives them onto the downstream AXI master AR or AW channel with a compliant VALID/READY handshake. Requests flagged with a translation fault are dropped and reported instead of issued. One instance serves the read address channel and one serves the write address channel.

## Interface
- BUF_SZ, 64: FIFO depth in entries, power of 2, ≥2; total capacity is BUF_SZ+1 (FIFO plus output register).
- ADDR_WIDTH, 32: translated address width.
- ID_WIDTH, 8: AXI ID width.
- USER_WIDTH, 2: AXI USER width.
- tx_clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_id / in_addr / in_len / in_size / in_burst / in_prot / in_cache / in_user / in_lock  in  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2 / 3 / 4 / USER_WIDTH / 1  translated request payload.
- in_fault  in  1  translation fault for this request; qualified by in_valid.
- in_valid  in  1  request valid from translator.
- in_ready  out  1  request accepted when in_valid & in_ready.
- out_id … out_lock  out  same widths as inputs  AXI AxID … AxLOCK.
- out_valid  out  1  AXI AxVALID.
- out_ready  in  1  AXI AxREADY.
- o_count  out  $clog2(BUF_SZ+1)+1  entries held (FIFO + output register).
- o_fault  out  1  one-cycle pulse per dropped request.
- o_fault_id  out  ID_WIDTH  ID of the last dropped request.
- o_fault_addr  out  ADDR_WIDTH  address of the last dropped request.
- o_fault_cnt  out  16  saturating count of dropped requests.

## Operation
- Payload packing is fixed: len[7:0], size[10:8], burst[12:11], prot[15:13], cache[19:16], lock[20], id above that, then addr, then user in the MSBs.
- in_ready = (fifo_count != BUF_SZ). It is combinational from registered state only and never depends on in_valid or out_ready.
- Accept = in_valid & in_ready. If in_fault=1, the entry is not stored. In the same edge, o_fault is set to 1, o_fault_id and o_fault_addr are captured, and o_fault_cnt increments, saturating at 16'hFFFF.
- Output register "free" = ~out_valid | out_ready.
- Non-faulted accept with the FIFO empty and the output register free: bypass, so the payload loads straight into the output register.
- Non-faulted accept otherwise: the payload is written to the FIFO tail.
- Output register free and FIFO non-empty: the FIFO head loads into the output register and is popped. This takes priority over bypass, so ordering is strictly preserved.
- A FIFO push and pop in the same cycle are both performed; the count is unchanged.
- out_valid, once high, stays high with a stable payload until out_ready is sampled high. out_valid never depends combinationally on out_ready.
- o_count = fifo_count + out_valid.
- No bypass of faulted entries. A fault while the FIFO is full cannot occur, because in_ready is low and nothing is accepted.

## Timing
- Reset (async assert, sync release): out_valid=0, all out_* payload=0, FIFO pointers and count=0, in_ready=1 once out of reset, o_count=0, o_fault=0, o_fault_id=0, o_fault_addr=0, o_fault_cnt=0. Reset mid-transfer discards all held entries.
- Latency for an empty block: accept at edge N, then out_valid is high from edge N (visible in cycle N+1).
- Latency through a non-empty FIFO: one edge from reaching the head with the output register free.
- Throughput is 1 request/cycle sustained while out_ready=1.
- o_fault is high for exactly the cycle following the faulting accept. Back-to-back faults hold it high for consecutive cycles.
- Pointers wrap modulo BUF_SZ.

## Test plan
- Single request: reset, then send addr=0x1000, id=0x05, len=3 with out_ready=1. Required: out_valid for exactly 1 cycle beginning one edge after accept, with matching payload; o_count returns to 0.
- Backpressure: hold out_ready=0 and stream 66 requests with addr=i*0x40. Required: in_ready drops after 65 accepts (BUF_SZ=64) and o_count=65. Then release out_ready. Required: 65 beats issue in order, payload stable while stalled, no request lost or duplicated.
- Fault drop: send three requests A, B(fault, id=0x7, addr=0xDEAD0000), C. Required: only A and C appear on the output; o_fault pulses once; o_fault_id=0x7, o_fault_addr=0xDEAD0000, o_fault_cnt=1.
- Simultaneous push/pop: with the FIFO holding 10 entries, out_ready=1 and in_valid=1 continuously for 20 cycles. Required: o_count constant at 11 and order preserved.
- Async reset mid-stream: assert reset between edges with 5 entries held. Required: out_valid=0 and o_count=0 immediately; after release the first new request issues with the bypass latency.
- Saturation: force 65540 faulted accepts. Required: o_fault_cnt holds at 16'hFFFF.
